// File: rtl/vga_plot_arbiter_if.sv
// Requester-side bus of the VGA plot arbiter: request/pixel inputs from the
// three drawing engines and the grant plus the single VGA write port.
interface vga_plot_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  pix_valid;
  logic [2:0]  pix_last;
  logic [26:0] pix_colour;
  logic [44:0] pix_xy;
  logic [2:0]  grant;
  logic [8:0]  vga_colour;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic        vga_plot;
  logic        busy;
  logic        timeout_flag;

  // Drawing engines (and the bench) drive requests and pixels.
  modport master (
    output req, pix_valid, pix_last, pix_colour, pix_xy,
    input  grant, vga_colour, vga_x, vga_y, vga_plot, busy, timeout_flag
  );

  // The arbiter consumes requests and drives grant and the VGA port.
  modport slave (
    input  req, pix_valid, pix_last, pix_colour, pix_xy,
    output grant, vga_colour, vga_x, vga_y, vga_plot, busy, timeout_flag
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter that lets one of three drawing engines own the VGA
// write port for a burst of pixels, filters invisible pixels and revokes
// a grant that sits idle for too long.
module vga_plot_arbiter #(
  parameter logic [8:0]  TRANSPARENT = 9'h1FF,
  parameter int unsigned TIMEOUT     = 4095,
  parameter int unsigned X_MAX       = 160,
  parameter int unsigned Y_MAX       = 120
) (
  input  logic              clk,
  input  logic              reset,
  vga_plot_arbiter_if.slave bus
);

  localparam int          CW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
  localparam logic [8:0]  X_LIM  = 9'(X_MAX);
  localparam logic [7:0]  Y_LIM  = 8'(Y_MAX);

  typedef enum logic [1:0] {IDLE, BURST, RELEASE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      grant_q, grant_d;
  logic [1:0]      gidx_q, gidx_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [8:0]      vga_colour_q, vga_colour_d;
  logic [7:0]      vga_x_q, vga_x_d;
  logic [6:0]      vga_y_q, vga_y_d;
  logic            vga_plot_q, vga_plot_d;
  logic            busy_q, busy_d;
  logic            timeout_flag_q, timeout_flag_d;

  // Per-requester views of the packed pixel buses.
  logic [8:0] col_arr [3];
  logic [7:0] x_arr   [3];
  logic [6:0] y_arr   [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_slice
    assign col_arr[gi] = bus.pix_colour[9*gi +: 9];
    assign x_arr[gi]   = bus.pix_xy[15*gi + 7 +: 8];
    assign y_arr[gi]   = bus.pix_xy[15*gi +: 7];
  end

  // Round-robin search starting at rr_ptr and wrapping modulo 3.
  logic       win_found;
  logic [1:0] win_idx;
  int         cand;
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 0;
    for (int k = 0; k < 3; k++) begin
      cand = (int'(rr_ptr_q) + k) % 3;
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = 2'(cand);
      end
    end
  end

  // Signals of the currently granted requester only; others are ignored.
  logic          sel_req, sel_valid, sel_last, accept, visible;
  logic [CW-1:0] cnt_inc;
  always_comb begin
    sel_req   = bus.req[gidx_q];
    sel_valid = bus.pix_valid[gidx_q];
    sel_last  = bus.pix_last[gidx_q];
    // A falling req still lets a final pixel through, but never a mid-burst one.
    accept    = (state_q == BURST) && sel_valid && (sel_req || sel_last);
    visible   = (col_arr[gidx_q] != TRANSPARENT) &&
                ({1'b0, x_arr[gidx_q]} < X_LIM) &&
                ({1'b0, y_arr[gidx_q]} < Y_LIM);
    cnt_inc   = (idle_cnt_q == TO_VAL) ? idle_cnt_q : idle_cnt_q + CW'(1);
  end

  // Next-state and next-output logic for the IDLE/BURST/RELEASE FSM.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    gidx_d         = gidx_q;
    rr_ptr_d       = rr_ptr_q;
    idle_cnt_d     = idle_cnt_q;
    vga_colour_d   = vga_colour_q;
    vga_x_d        = vga_x_q;
    vga_y_d        = vga_y_q;
    vga_plot_d     = 1'b0;
    timeout_flag_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = BURST;
          grant_d    = 3'b001 << win_idx;
          gidx_d     = win_idx;
          idle_cnt_d = '0;
        end
      end
      BURST: begin
        if (accept) begin
          vga_colour_d = col_arr[gidx_q];
          vga_x_d      = x_arr[gidx_q];
          vga_y_d      = y_arr[gidx_q];
          vga_plot_d   = visible;
          idle_cnt_d   = '0;
          // pix_last wins over a watchdog expiry in the same cycle.
          if (sel_last) begin
            state_d = RELEASE;
            grant_d = 3'b000;
          end
        end else if (!sel_req) begin
          state_d = RELEASE;
          grant_d = 3'b000;
        end else begin
          idle_cnt_d = cnt_inc;
          if (cnt_inc == TO_VAL) begin
            state_d        = RELEASE;
            grant_d        = 3'b000;
            timeout_flag_d = 1'b1;
          end
        end
      end
      RELEASE: begin
        grant_d  = 3'b000;
        rr_ptr_d = (gidx_q == 2'd2) ? 2'd0 : gidx_q + 2'd1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset overrides everything, including a pixel in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      grant_q        <= 3'b000;
      gidx_q         <= 2'd0;
      rr_ptr_q       <= 2'd0;
      idle_cnt_q     <= '0;
      vga_colour_q   <= 9'd0;
      vga_x_q        <= 8'd0;
      vga_y_q        <= 7'd0;
      vga_plot_q     <= 1'b0;
      busy_q         <= 1'b0;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      gidx_q         <= gidx_d;
      rr_ptr_q       <= rr_ptr_d;
      idle_cnt_q     <= idle_cnt_d;
      vga_colour_q   <= vga_colour_d;
      vga_x_q        <= vga_x_d;
      vga_y_q        <= vga_y_d;
      vga_plot_q     <= vga_plot_d;
      busy_q         <= busy_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.vga_colour   = vga_colour_q;
  assign bus.vga_x        = vga_x_q;
  assign bus.vga_y        = vga_y_q;
  assign bus.vga_plot     = vga_plot_q;
  assign bus.busy         = busy_q;
  assign bus.timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: a vector table covering reset,
// bursts, round-robin order, filtering and aborts, then hand-built
// sequences for the watchdog corner cases (TIMEOUT = 8).
module tb_vga_plot_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_plot_arbiter_if bus ();

  vga_plot_arbiter #(.TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [2:0]  req, valid, last;
    logic [26:0] colour;
    logic [44:0] xy;
    logic [2:0]  e_grant;
    logic        e_plot, e_busy, e_tf, chk_pix;
    logic [8:0]  e_col;
    logic [7:0]  e_x;
    logic [6:0]  e_y;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Builds one row; the real pixel goes in slot src, other slots carry a
  // visible decoy pixel so that reading the wrong slot is caught.
  function automatic vec_t mk(string nm, logic r, logic [2:0] rq, logic [2:0] vl,
                              logic [2:0] ls, int src, logic [8:0] col,
                              logic [7:0] x, logic [6:0] y, logic [2:0] eg,
                              logic ep, logic eb, logic et, logic cp,
                              logic [8:0] ec, logic [7:0] ex, logic [6:0] ey);
    vec_t v;
    v.name = nm; v.rst = r; v.req = rq; v.valid = vl; v.last = ls;
    for (int i = 0; i < 3; i++) begin
      v.colour[9*i +: 9] = 9'h055;
      v.xy[15*i +: 15]   = {8'd50, 7'd50};
    end
    v.colour[9*src +: 9] = col;
    v.xy[15*src +: 15]   = {x, y};
    v.e_grant = eg; v.e_plot = ep; v.e_busy = eb; v.e_tf = et; v.chk_pix = cp;
    v.e_col = ec; v.e_x = ex; v.e_y = ey;
    return v;
  endfunction

  function automatic void chk(string nm, string what, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, what, act, exp);
    end
  endfunction

  task automatic run(input vec_t v);
    rst            = v.rst;
    bus.req        = v.req;
    bus.pix_valid  = v.valid;
    bus.pix_last   = v.last;
    bus.pix_colour = v.colour;
    bus.pix_xy     = v.xy;
    @(posedge clk);
    #1;
    $display("%0t %-10s grant=%b plot=%b col=%h x=%0d y=%0d busy=%b tf=%b", $time, v.name,
             bus.grant, bus.vga_plot, bus.vga_colour, bus.vga_x, bus.vga_y, bus.busy,
             bus.timeout_flag);
    chk(v.name, "grant", 32'(bus.grant), 32'(v.e_grant));
    chk(v.name, "plot", 32'(bus.vga_plot), 32'(v.e_plot));
    chk(v.name, "busy", 32'(bus.busy), 32'(v.e_busy));
    chk(v.name, "tflag", 32'(bus.timeout_flag), 32'(v.e_tf));
    if (v.chk_pix) begin
      chk(v.name, "colour", 32'(bus.vga_colour), 32'(v.e_col));
      chk(v.name, "x", 32'(bus.vga_x), 32'(v.e_x));
      chk(v.name, "y", 32'(bus.vga_y), 32'(v.e_y));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0; bus.pix_valid = '0; bus.pix_last = '0;
    bus.pix_colour = '0; bus.pix_xy = '0;

    //                name         rst req     valid   last  src col     x    y     grant   pl  bs  tf  cp  col     x    y
    vecs.push_back(mk("reset",     1, 3'b000, 3'b000, 3'b000, 0, 9'h000, 0,   0,   3'b000, 0, 0, 0, 1, 9'h000, 0,   0));
    vecs.push_back(mk("noreq",     0, 3'b000, 3'b000, 3'b000, 0, 9'h000, 0,   0,   3'b000, 0, 0, 0, 1, 9'h000, 0,   0));
    // Single requester burst of four pixels.
    vecs.push_back(mk("b_grant",   0, 3'b010, 3'b000, 3'b000, 1, 9'h000, 0,   0,   3'b010, 0, 1, 0, 0, 9'h000, 0,   0));
    vecs.push_back(mk("b_px0",     0, 3'b010, 3'b010, 3'b000, 1, 9'h0F0, 10,  20,  3'b010, 1, 1, 0, 1, 9'h0F0, 10,  20));
    vecs.push_back(mk("b_px1",     0, 3'b010, 3'b010, 3'b000, 1, 9'h0F0, 11,  20,  3'b010, 1, 1, 0, 1, 9'h0F0, 11,  20));
    vecs.push_back(mk("b_px2",     0, 3'b010, 3'b010, 3'b000, 1, 9'h0F0, 12,  20,  3'b010, 1, 1, 0, 1, 9'h0F0, 12,  20));
    vecs.push_back(mk("b_px3last", 0, 3'b010, 3'b010, 3'b010, 1, 9'h0F0, 13,  20,  3'b000, 1, 1, 0, 1, 9'h0F0, 13,  20));
    vecs.push_back(mk("b_idle",    0, 3'b000, 3'b000, 3'b000, 1, 9'h000, 0,   0,   3'b000, 0, 0, 0, 1, 9'h0F0, 13,  20));
    vecs.push_back(mk("b_rr2",     0, 3'b111, 3'b000, 3'b000, 0, 9'h000, 0,   0,   3'b100, 0, 1, 0, 0, 9'h000, 0,   0));
    vecs.push_back(mk("b_drop",    0, 3'b000, 3'b000, 3'b000, 0, 9'h000, 0,   0,   3'b000, 0, 1, 0, 0, 9'h000, 0,   0));
    vecs.push_back(mk("b_end",     0, 3'b000, 3'b000, 3'b000, 0, 9'h000, 0,   0,   3'b000, 0, 0, 0, 0, 9'h000, 0,   0));
    vecs.push_back(mk("reset2",    1, 3'b000, 3'b000, 3'b000, 0, 9'h000, 0,   0,   3'b000, 0, 0, 0, 1, 9'h000, 0,   0));
    // Round-robin with all three requesting.
    vecs.push_back(mk("c_g0",      0, 3'b111, 3'b000, 3'b000, 0, 9'h000, 0,   0,   3'b001, 0, 1, 0, 0, 9'h000, 0,   0));
    vecs.push_back(mk("c_p0",      0, 3'b111, 3'b001, 3'b001, 0, 9'h011, 1,   1,   3'b000, 1, 1, 0, 1, 9'h011, 1,   1));
    vecs.push_back(mk("c_gap0",    0, 3'b111, 3'b000, 3'b000, 0, 9'h000, 0,   0,   3'b000, 0, 0, 0, 0, 9'h000, 0,   0));
    vecs.push_back(mk("c_g1",      0, 3'b111, 3'b000, 3'b000, 0, 9'h000, 0,   0,   3'b010, 0, 1, 0, 0, 9'h000, 0,   0));
    vecs.push_back(mk("c_p1",      0, 3'b111, 3'b010, 3'b010, 1, 9'h022, 2,   2,   3'b000, 1, 1, 0, 1, 9'h022, 2,   2));
    vecs.push_back(mk("c_gap1",    0, 3'b111, 3'b000, 3'b000, 0, 9'h000, 0,   0,   3'b000, 0, 0, 0, 0, 9'h000, 0,   0));
    vecs.push_back(mk("c_g2",      0, 3'b111, 3'b000, 3'b000, 0, 9'h000, 0,   0,   3'b100, 0, 1, 0, 0, 9'h000, 0,   0));
    vecs.push_back(mk("c_p2",      0, 3'b111, 3'b111, 3'b111, 2, 9'h033, 3,   3,   3'b000, 1, 1, 0, 1, 9'h033, 3,   3));
    vecs.push_back(mk("c_gap2",    0, 3'b111, 3'b000, 3'b000, 0, 9'h000, 0,   0,   3'b000, 0, 0, 0, 0, 9'h000, 0,   0));
    vecs.push_back(mk("c_g0b",     0, 3'b111, 3'b000, 3'b000, 0, 9'h000, 0,   0,   3'b001, 0, 1, 0, 0, 9'h000, 0,   0));
    vecs.push_back(mk("c_drop",    0, 3'b000, 3'b000, 3'b000, 0, 9'h000, 0,   0,   3'b000, 0, 1, 0, 0, 9'h000, 0,   0));
    vecs.push_back(mk("c_end",     0, 3'b000, 3'b000, 3'b000, 0, 9'h000, 0,   0,   3'b000, 0, 0, 0, 0, 9'h000, 0,   0));
    // Filtering: transparent, x out of range, y out of range, last corner pixel.
    vecs.push_back(mk("d_grant",   0, 3'b010, 3'b000, 3'b000, 1, 9'h000, 0,   0,   3'b010, 0, 1, 0, 0, 9'h000, 0,   0));
    vecs.push_back(mk("d_transp",  0, 3'b010, 3'b010, 3'b000, 1, 9'h1FF, 5,   5,   3'b010, 0, 1, 0, 1, 9'h1FF, 5,   5));
    vecs.push_back(mk("d_x160",    0, 3'b010, 3'b010, 3'b000, 1, 9'h100, 160, 5,   3'b010, 0, 1, 0, 1, 9'h100, 160, 5));
    vecs.push_back(mk("d_y120",    0, 3'b010, 3'b010, 3'b000, 1, 9'h100, 5,   120, 3'b010, 0, 1, 0, 1, 9'h100, 5,   120));
    vecs.push_back(mk("d_corner",  0, 3'b010, 3'b010, 3'b010, 1, 9'h100, 159, 119, 3'b000, 1, 1, 0, 1, 9'h100, 159, 119));
    vecs.push_back(mk("d_end",     0, 3'b000, 3'b000, 3'b000, 0, 9'h000, 0,   0,   3'b000, 0, 0, 0, 0, 9'h000, 0,   0));
    // Abort: req[2] drops mid-burst with a non-last pixel offered.
    vecs.push_back(mk("e_grant",   0, 3'b100, 3'b000, 3'b000, 2, 9'h000, 0,   0,   3'b100, 0, 1, 0, 0, 9'h000, 0,   0));
    vecs.push_back(mk("e_px",      0, 3'b100, 3'b100, 3'b000, 2, 9'h0AA, 7,   7,   3'b100, 1, 1, 0, 1, 9'h0AA, 7,   7));
    vecs.push_back(mk("e_abort",   0, 3'b000, 3'b100, 3'b000, 2, 9'h0BB, 8,   8,   3'b000, 0, 1, 0, 1, 9'h0AA, 7,   7));
    vecs.push_back(mk("e_end",     0, 3'b000, 3'b000, 3'b000, 0, 9'h000, 0,   0,   3'b000, 0, 0, 0, 0, 9'h000, 0,   0));
    // req falls together with an accepted last pixel.
    vecs.push_back(mk("e_grant0",  0, 3'b001, 3'b000, 3'b000, 0, 9'h000, 0,   0,   3'b001, 0, 1, 0, 0, 9'h000, 0,   0));
    vecs.push_back(mk("e_lastdrop",0, 3'b000, 3'b001, 3'b001, 0, 9'h0CC, 9,   9,   3'b000, 1, 1, 0, 1, 9'h0CC, 9,   9));
    vecs.push_back(mk("e_end2",    0, 3'b000, 3'b000, 3'b000, 0, 9'h000, 0,   0,   3'b000, 0, 0, 0, 0, 9'h000, 0,   0));
    // Reset one cycle after an accept discards the next pixel.
    vecs.push_back(mk("f_grant",   0, 3'b010, 3'b000, 3'b000, 1, 9'h000, 0,   0,   3'b010, 0, 1, 0, 0, 9'h000, 0,   0));
    vecs.push_back(mk("f_px",      0, 3'b010, 3'b010, 3'b000, 1, 9'h0DD, 4,   4,   3'b010, 1, 1, 0, 1, 9'h0DD, 4,   4));
    vecs.push_back(mk("f_reset",   1, 3'b010, 3'b010, 3'b000, 1, 9'h0DE, 4,   5,   3'b000, 0, 0, 0, 1, 9'h000, 0,   0));
    vecs.push_back(mk("f_after",   0, 3'b000, 3'b000, 3'b000, 0, 9'h000, 0,   0,   3'b000, 0, 0, 0, 0, 9'h000, 0,   0));

    foreach (vecs[i]) run(vecs[i]);

    // Watchdog: an accepted pixel restarts the idle count, then 8 idle
    // cycles revoke the grant (rr_ptr is 0 after the reset above).
    run(mk("t_grant", 0, 3'b001, 3'b000, 3'b000, 0, 9'h000, 0, 0, 3'b001, 0, 1, 0, 0, 9'h000, 0, 0));
    for (int i = 0; i < 5; i++)
      run(mk("t_idle_a", 0, 3'b001, 3'b000, 3'b000, 0, 9'h000, 0, 0, 3'b001, 0, 1, 0, 0, 9'h000, 0, 0));
    run(mk("t_px", 0, 3'b001, 3'b001, 3'b000, 0, 9'h0A5, 20, 30, 3'b001, 1, 1, 0, 1, 9'h0A5, 20, 30));
    for (int i = 0; i < 7; i++)
      run(mk("t_idle_b", 0, 3'b001, 3'b000, 3'b000, 0, 9'h000, 0, 0, 3'b001, 0, 1, 0, 0, 9'h000, 0, 0));
    run(mk("t_expire", 0, 3'b001, 3'b000, 3'b000, 0, 9'h000, 0, 0, 3'b000, 0, 1, 1, 0, 9'h000, 0, 0));
    run(mk("t_end", 0, 3'b000, 3'b000, 3'b000, 0, 9'h000, 0, 0, 3'b000, 0, 0, 0, 1, 9'h0A5, 20, 30));

    // pix_last on the cycle the watchdog would fire: plotted, no flag.
    // rr_ptr is now 1, so requester 2 wins with only req[2] set.
    run(mk("s_grant", 0, 3'b100, 3'b000, 3'b000, 2, 9'h000, 0, 0, 3'b100, 0, 1, 0, 0, 9'h000, 0, 0));
    for (int i = 0; i < 7; i++)
      run(mk("s_idle", 0, 3'b100, 3'b000, 3'b000, 2, 9'h000, 0, 0, 3'b100, 0, 1, 0, 0, 9'h000, 0, 0));
    run(mk("s_last", 0, 3'b100, 3'b100, 3'b100, 2, 9'h0EE, 6, 6, 3'b000, 1, 1, 0, 1, 9'h0EE, 6, 6));
    run(mk("s_end", 0, 3'b000, 3'b000, 3'b000, 0, 9'h000, 0, 0, 3'b000, 0, 0, 0, 0, 9'h000, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_plot_arbiter.md
VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 Parameter TRANSPARENT, default 9'h1FF, is the colour value that is never plotted.
REQ-002 Parameter TIMEOUT, default 4095, is the maximum number of idle cycles allowed within a grant.
REQ-003 Parameter X_MAX, default 160, is the exclusive upper bound on x.
REQ-004 Parameter Y_MAX, default 120, is the exclusive upper bound on y.
REQ-005 clk  in  1  system clock (CLOCK_50 at top level); the block SHALL use one clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req  in  3  per-requester bus request; index 0 is start/end text, 1 is towers, 2 is cars.
REQ-008 pix_valid  in  3  per-requester pixel strobe.
REQ-009 pix_last  in  3  per-requester marker for the final pixel of a burst.
REQ-010 pix_colour  in  27  requester i colour is in bits [9i+8:9i].
REQ-011 pix_xy  in  45  requester i coordinate is in bits [15i+14:15i], ordered {x[7:0], y[6:0]}.
REQ-012 grant  out  3  one-hot grant, or all zero; it is registered.
REQ-013 vga_colour  out  9  colour to vga_adapter.
REQ-014 vga_x  out  8  x coordinate to vga_adapter.
REQ-015 vga_y  out  7  y coordinate to vga_adapter.
REQ-016 vga_plot  out  1  single-cycle write strobe to vga_adapter.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 timeout_flag  out  1  single-cycle pulse when a grant is revoked by the watchdog.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, BURST and RELEASE.
REQ-020 In IDLE, if req is nonzero, the block SHALL pick the winner by round-robin, searching from rr_ptr upward modulo 3, set grant to that one-hot value at the next edge, and enter BURST.
REQ-021 In IDLE with req equal to 0, grant SHALL stay 0 and the FSM SHALL stay in IDLE.
REQ-022 In BURST, a pixel from requester g SHALL be accepted on any cycle in which grant[g] and pix_valid[g] are both high; the requester SHALL treat grant[g] as its ready signal.
REQ-023 pix_valid and pix_last from non-granted requesters SHALL be ignored.
REQ-024 An accepted pixel SHALL appear on vga_colour, vga_x and vga_y one cycle after acceptance, with vga_plot high for that one cycle only.
REQ-025 vga_plot SHALL stay low for an accepted pixel whose colour equals TRANSPARENT, or whose x >= X_MAX, or whose y >= Y_MAX; vga_colour, vga_x and vga_y SHALL still update.
REQ-026 BURST SHALL go to RELEASE on an accepted pixel with pix_last[g] high; that last pixel SHALL still be plotted under the rules of REQ-025.
REQ-027 BURST SHALL go to RELEASE when req[g] is low without a pix_last, and no pixel SHALL be accepted on that cycle.
REQ-028 An idle counter SHALL be cleared on entry to BURST and on every accepted pixel, and SHALL increment on every other BURST cycle.
REQ-029 When the idle counter reaches TIMEOUT, BURST SHALL go to RELEASE and timeout_flag SHALL pulse for one cycle.
REQ-030 In RELEASE, grant SHALL be 0, rr_ptr SHALL become (g+1) mod 3, and the FSM SHALL return to IDLE on the next edge.
REQ-031 Successive grants SHALL therefore be separated by at least one cycle with grant equal to 0.
REQ-032 If pix_last and the timeout occur in the same cycle, pix_last SHALL take precedence and timeout_flag SHALL stay low.
REQ-033 If req[g] falls in the same cycle as an accepted pix_last, the pixel SHALL be plotted and the transition SHALL be as for pix_last.
REQ-034 The idle counter SHALL saturate and SHALL NOT wrap.
REQ-035 The coordinate bound checks SHALL be unsigned comparisons at the full 8-bit and 7-bit port widths.

Reset
REQ-036 When reset is high at an edge, the block SHALL enter IDLE and set rr_ptr to 0, grant to 0, vga_colour to 0, vga_x to 0, vga_y to 0, vga_plot to 0, busy to 0, timeout_flag to 0 and the idle counter to 0.
REQ-037 Reset asserted mid-burst SHALL discard the pixel in flight, so vga_plot is 0 in the following cycle.
REQ-038 Reset SHALL take precedence over all other events.

Verification
REQ-039 Single requester: req=3'b010, then 4 pixels with colour 9'h0F0 at (10,20)..(13,20) and pix_last on the 4th -> grant=010, 4 plot pulses each one cycle after acceptance, then RELEASE, then IDLE with rr_ptr=2.
REQ-040 Round-robin fairness: req=3'b111 held, each requester sends a 1-pixel burst -> grant order 001, 010, 100, 001, with a zero-grant cycle between each grant.
REQ-041 Filtering: pixels with colour=9'h1FF, (160,5), (5,120) and (159,119) -> vga_plot asserted only for (159,119).
REQ-042 Watchdog with TIMEOUT=8: grant to requester 0, no pix_valid -> timeout_flag pulses after 8 idle cycles, grant=0, rr_ptr=1.
REQ-043 Abort and reset: req[2] drops mid-burst -> RELEASE with no plot on that cycle; separately, reset asserted one cycle after an accept -> vga_plot=0 and grant=0 on the next cycle.
REQ-044 Simultaneous events: pix_last on the TIMEOUT cycle -> plot asserted and timeout_flag=0.
